// File: rtl/lvds_buf_ctrl.sv
// Ping-pong capture controller: streams LVDS nibbles into two sample buffers and tracks software reads.
// Optional macro LVDS_BUF_CTRL_DROP_CNT_EN builds the saturating dropped-sample counter.
module lvds_buf_ctrl #(
    parameter int unsigned C_BUF_DEPTH  = 1024,
    parameter int unsigned C_ADDR_WIDTH = 10
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [3:0]              SAMPLE_DATA,
    input  logic                    SAMPLE_VALID,
    input  logic                    CAP_START,
    input  logic                    CAP_ABORT,
    input  logic                    RD_DONE,
    output logic                    BUF_WE,
    output logic                    BUF_SEL,
    output logic [C_ADDR_WIDTH-1:0] BUF_WADDR,
    output logic [3:0]              BUF_WDATA,
    output logic [1:0]              BUF_FULL,
    output logic                    RD_BUF,
    output logic                    BUSY,
    output logic                    OVERRUN,
    output logic [15:0]             DROP_COUNT,
    output logic                    LED0
);

    localparam int unsigned DCNT_W = 16;
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_LAST = C_ADDR_WIDTH'(C_BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [C_ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic                    wr_sel, wr_sel_nxt;
    logic                    we_nxt;
    logic                    sel_o_nxt;
    logic [C_ADDR_WIDTH-1:0] waddr_o_nxt;
    logic [3:0]              wdata_nxt;
    logic [1:0]              full_nxt;
    logic                    rd_nxt;
    logic                    overrun_nxt;
    logic                    busy_nxt;
    logic                    rel_evt;
    logic                    drop_evt;
    logic                    cap_go;

    assign rel_evt  = RD_DONE && BUF_FULL[RD_BUF];
    assign drop_evt = (state == ST_WAIT) && SAMPLE_VALID && !CAP_ABORT;
    assign cap_go   = (state == ST_IDLE) && CAP_START && !CAP_ABORT;

    // Next-state and next-output logic; a read release is applied before the full check
    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        wr_sel_nxt  = wr_sel;
        we_nxt      = 1'b0;
        sel_o_nxt   = BUF_SEL;
        waddr_o_nxt = BUF_WADDR;
        wdata_nxt   = BUF_WDATA;
        full_nxt    = BUF_FULL;
        rd_nxt      = RD_BUF;
        overrun_nxt = OVERRUN;

        if (rel_evt) begin
            full_nxt[RD_BUF] = 1'b0;
            rd_nxt           = ~RD_BUF;
        end

        case (state)
            ST_IDLE: begin
                if (CAP_START) begin
                    state_nxt   = ST_FILL;
                    wr_addr_nxt = '0;
                    wr_sel_nxt  = 1'b0;
                    sel_o_nxt   = 1'b0;
                    waddr_o_nxt = '0;
                    full_nxt    = 2'b00;
                    rd_nxt      = 1'b0;
                end
            end
            ST_FILL: begin
                if (SAMPLE_VALID) begin
                    we_nxt      = 1'b1;
                    wdata_nxt   = SAMPLE_DATA;
                    waddr_o_nxt = wr_addr;
                    sel_o_nxt   = wr_sel;
                    if (wr_addr == ADDR_LAST) begin
                        full_nxt[wr_sel] = 1'b1;
                        if (!full_nxt[~wr_sel]) begin
                            wr_sel_nxt  = ~wr_sel;
                            wr_addr_nxt = '0;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end else begin
                        wr_addr_nxt = wr_addr + C_ADDR_WIDTH'(1);
                    end
                end
            end
            ST_WAIT: begin
                // The buffer just released is the one that was oldest, i.e. RD_BUF before toggling
                if (rel_evt) begin
                    state_nxt   = ST_FILL;
                    wr_sel_nxt  = RD_BUF;
                    wr_addr_nxt = '0;
                    sel_o_nxt   = RD_BUF;
                    waddr_o_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (drop_evt) begin
            overrun_nxt = 1'b1;
        end
        if (cap_go) begin
            overrun_nxt = 1'b0;
        end

        if (CAP_ABORT) begin
            state_nxt   = ST_IDLE;
            we_nxt      = 1'b0;
            full_nxt    = 2'b00;
            rd_nxt      = 1'b0;
            wr_addr_nxt = '0;
            wr_sel_nxt  = 1'b0;
            waddr_o_nxt = '0;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state     <= ST_IDLE;
            wr_addr   <= '0;
            wr_sel    <= 1'b0;
            BUF_WE    <= 1'b0;
            BUF_SEL   <= 1'b0;
            BUF_WADDR <= '0;
            BUF_WDATA <= 4'h0;
            BUF_FULL  <= 2'b00;
            RD_BUF    <= 1'b0;
            BUSY      <= 1'b0;
            OVERRUN   <= 1'b0;
            LED0      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_sel    <= wr_sel_nxt;
            BUF_WE    <= we_nxt;
            BUF_SEL   <= sel_o_nxt;
            BUF_WADDR <= waddr_o_nxt;
            BUF_WDATA <= wdata_nxt;
            BUF_FULL  <= full_nxt;
            RD_BUF    <= rd_nxt;
            BUSY      <= busy_nxt;
            OVERRUN   <= overrun_nxt;
            LED0      <= busy_nxt;
        end
    end

`ifdef LVDS_BUF_CTRL_DROP_CNT_EN
    logic [DCNT_W-1:0] drop_cnt, drop_cnt_nxt;

    // Saturating count of samples discarded while both buffers are full
    always_comb begin
        drop_cnt_nxt = drop_cnt;
        if (cap_go) begin
            drop_cnt_nxt = '0;
        end else if (drop_evt && (drop_cnt != {DCNT_W{1'b1}})) begin
            drop_cnt_nxt = drop_cnt + DCNT_W'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_cnt_nxt;
        end
    end

    assign DROP_COUNT = drop_cnt;
`else
    assign DROP_COUNT = DCNT_W'(0);
`endif

endmodule
